inst_fetch: RTL

Byte-serial instruction fetch and length-decode stage, directly upstream of the ALU. Reads x86-subset instruction bytes from byte-wide instruction memory at the current eip and assembles the left-aligned `ope` window, `immidiate_data`, and `num_of_ope` consumed by the ALU. Hands each instruction downstream over a valid/ready pair. Accepts an eip redirect from the control-flow path (call, ret, jne, jmp).

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/op_length.sv | 63 ++++++
 rtl/inst_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcode byte constants for the
// supported x86 subset, the fetch FSM state type and ModRM mod field values.
package cpu_pkg;

  // Supported opcode bytes
  localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
  localparam logic [7:0] OP_PUSH_EBX    = 8'h53;
  localparam logic [7:0] OP_POP_EBP     = 8'h5d;
  localparam logic [7:0] OP_RET         = 8'hc3;
  localparam logic [7:0] OP_LEAVE       = 8'hc9;
  localparam logic [7:0] OP_MOV_RM_R    = 8'h89;
  localparam logic [7:0] OP_MOV_R_RM    = 8'h8b;
  localparam logic [7:0] OP_MOV_EAX_IMM = 8'hb8;
  localparam logic [7:0] OP_CALL        = 8'he8;
  localparam logic [7:0] OP_PUSH_IMM8   = 8'h6a;
  localparam logic [7:0] OP_GRP83       = 8'h83;
  localparam logic [7:0] OP_JNE         = 8'h75;
  localparam logic [7:0] OP_JMP         = 8'heb;

  // ModRM mod field (byte1[7:6])
  localparam logic [1:0] MOD_MEM    = 2'b00;
  localparam logic [1:0] MOD_DISP8  = 2'b01;
  localparam logic [1:0] MOD_DISP32 = 2'b10;
  localparam logic [1:0] MOD_REG    = 2'b11;

  // Longest supported instruction, in bytes
  localparam int unsigned MAX_INST_BYTES = 5;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/op_length.sv
// Instruction length decoder for the supported x86 subset.
// Ports:
//   byte0        in  8  opcode byte
//   byte1        in  8  ModRM byte (only meaningful when byte1_valid)
//   byte1_valid  in  1  byte1 has been fetched
//   length       out 4  instruction length in bytes (1..5)
//   illegal      out 1  byte0 is not a supported opcode
// While byte1 is still unknown, ModRM opcodes report length 2, the shortest
// form, so the fetcher always goes on to read the ModRM byte.
module op_length
  import cpu_pkg::*;
(
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic       byte1_valid,
  output logic [3:0] length,
  output logic       illegal
);

  logic [1:0] w_mod;
  logic       w_unused_reg_rm;

  assign w_mod = byte1[7:6];
  // reg and r/m fields never change the length within this subset
  assign w_unused_reg_rm = ^byte1[5:0];

  always_comb begin
    length  = 4'd1;
    illegal = 1'b0;
    case (byte0)
      OP_PUSH_EBP, OP_PUSH_EBX, OP_POP_EBP, OP_RET, OP_LEAVE: begin
        length = 4'd1;
      end
      OP_PUSH_IMM8, OP_JNE, OP_JMP: begin
        length = 4'd2;
      end
      OP_MOV_RM_R, OP_MOV_R_RM: begin
        if (byte1_valid && (w_mod == MOD_DISP8)) begin
          length = 4'd3;
        end else begin
          length = 4'd2;
        end
      end
      OP_GRP83: begin
        if (!byte1_valid) begin
          length = 4'd2;
        end else if (w_mod == MOD_DISP8) begin
          length = 4'd4;
        end else begin
          length = 4'd3;
        end
      end
      OP_MOV_EAX_IMM, OP_CALL: begin
        length = 4'd5;
      end
      default: begin
        length  = 4'd1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch and length decode ahead of the ALU.
// Reads one instruction byte per memory transaction starting at eip, packs
// the bytes left-aligned into ope/immidiate_data and hands the instruction
// downstream with a valid/ready handshake. A redirect reloads eip at once.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   mem_req/mem_addr        byte read request and address (eip + count)
//   mem_ack/mem_rdata       read completion with data in the same cycle
//   redirect/redirect_eip   one-cycle eip reload from control flow
//   ope                     instruction bytes 0..3, byte0 in [31:24]
//   immidiate_data          instruction byte 4 in [31:24]
//   num_of_ope              instruction length 1..5
//   inst_eip                address of byte0
//   illegal                 byte0 not in the supported opcode set
//   inst_valid/inst_ready   downstream handshake
module inst_fetch
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_eip,
  output logic [31:0] ope,
  output logic [31:0] immidiate_data,
  output logic [3:0]  num_of_ope,
  output logic [31:0] inst_eip,
  output logic        illegal,
  output logic        inst_valid,
  input  logic        inst_ready
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0]     r_eip;
  logic [2:0]      r_count;
  logic [4:0][7:0] r_slot;   // r_slot[0] is byte0
  logic [3:0]      r_len;
  logic            r_illegal;
  logic            r_run;    // low for the first cycle out of reset

  logic       w_take;
  logic [7:0] w_byte0;
  logic [7:0] w_byte1;
  logic       w_byte1_valid;
  logic [3:0] w_len;
  logic       w_illegal;
  logic [2:0] w_cnt_inc;
  logic       w_done;
  logic       w_accept;

  // A byte lands this cycle
  assign w_take = (r_state == ST_FETCH) && r_run && mem_ack;

  // Decode on the byte arriving now so the last byte moves straight to HOLD
  assign w_byte0       = (w_take && (r_count == 3'd0)) ? mem_rdata : r_slot[0];
  assign w_byte1       = (w_take && (r_count == 3'd1)) ? mem_rdata : r_slot[1];
  assign w_byte1_valid = (r_count >= 3'd2) || (w_take && (r_count == 3'd1));

  op_length u_op_length (
    .byte0       (w_byte0),
    .byte1       (w_byte1),
    .byte1_valid (w_byte1_valid),
    .length      (w_len),
    .illegal     (w_illegal)
  );

  assign w_cnt_inc = r_count + 3'd1;
  assign w_done    = w_take && ({1'b0, w_cnt_inc} >= w_len);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    inst_valid  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = r_run;
        if (w_done) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
    if (redirect) begin
      w_state_nxt = ST_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_eip     <= 32'd0;
      r_count   <= 3'd0;
      r_slot    <= '0;
      r_len     <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect) begin
        // Wins over accept: a coincident transfer still completes downstream
        r_eip   <= redirect_eip;
        r_count <= 3'd0;
        r_slot  <= '0;
      end else if (w_accept) begin
        r_eip   <= r_eip + {28'd0, r_len};
        r_count <= 3'd0;
        r_slot  <= '0;
      end else if (w_take) begin
        for (int i = 0; i < MAX_INST_BYTES; i++) begin
          if (r_count == 3'(i)) begin
            r_slot[i] <= mem_rdata;
          end
        end
        r_count <= w_cnt_inc;
        if (w_done) begin
          r_len     <= w_len;
          r_illegal <= w_illegal;
        end
      end
    end
  end

  assign mem_addr       = r_eip + {29'd0, r_count};
  assign ope            = {r_slot[0], r_slot[1], r_slot[2], r_slot[3]};
  assign immidiate_data = {r_slot[4], 24'd0};
  assign num_of_ope     = r_len;
  assign inst_eip       = r_eip;
  assign illegal        = r_illegal;

endmodule
